tmr_mc: RTL and testbench

TMR_MC -- requirements
Module: tmr_mc

---
 rtl/tmr_mc.sv | 187 ++++++++++++++++++
 tb/tb_tmr_mc.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_mc.sv
// Timer/counter with prescaler, external count input, capture and
// per-channel compare/PWM outputs behind a small word-addressed register file.
module tmr_mc #(
    parameter int tmr_w = 16,
    parameter int psc_w = 8,
    parameter int ch_n  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      addr,
    input  logic            we,
    input  logic [31:0]     wd,
    output logic [31:0]     rd,
    output logic            irq,
    input  logic            tmr_in,
    input  logic            cap_in,
    output logic [ch_n-1:0] tmr_out
);
    localparam int is_w   = ch_n + 3;
    localparam int ovf_b  = ch_n;
    localparam int cap_b  = ch_n + 1;
    localparam int covr_b = ch_n + 2;

    logic [4:0]       cr_q, cr_d;
    logic [psc_w-1:0] psc_q, psc_d, pre_q, pre_d;
    logic [tmr_w-1:0] re_q, re_d, cnt_q, cnt_d, cap_q, cap_d;
    logic [is_w-1:0]  ie_q, ie_d, is_q, is_d;
    logic [tmr_w-1:0] cmp_q [ch_n];
    logic [tmr_w-1:0] cmp_d [ch_n];
    logic [2:0]       tin_q, tin_d, cin_q, cin_d;
    logic [ch_n-1:0]  out_q, out_d;
    logic             irq_q, irq_d;

    logic [5:0]      widx;
    logic            wr_cr, wr_psc, wr_re, wr_cnt, wr_ie, wr_is;
    logic            en, t_edge, c_edge, tick, tick_eff;
    logic [is_w-1:0] set_v, clr_v;
    logic            unused_ok;

    assign unused_ok = ^{addr[1:0], wd};

    assign widx   = addr[7:2];
    assign wr_cr  = we && (widx == 6'd0);
    assign wr_psc = we && (widx == 6'd1);
    assign wr_re  = we && (widx == 6'd2);
    assign wr_cnt = we && (widx == 6'd3);
    assign wr_ie  = we && (widx == 6'd4);
    assign wr_is  = we && (widx == 6'd5);

    // sync chain: [0] first stage, [1] second stage, [2] history
    assign en     = cr_q[0];
    assign t_edge = cr_q[3] ? (tin_q[2] & ~tin_q[1]) : (tin_q[1] & ~tin_q[2]);
    assign c_edge = cr_q[4] ? (cin_q[2] & ~cin_q[1]) : (cin_q[1] & ~cin_q[2]);
    assign tick   = en && (cr_q[2] ? t_edge : (pre_q == psc_q));
    // a bus write of CNT takes precedence over the whole tick
    assign tick_eff = tick && !wr_cnt;

    always_comb begin
        cr_d  = cr_q;
        psc_d = psc_q;
        pre_d = pre_q;
        re_d  = re_q;
        cnt_d = cnt_q;
        cap_d = cap_q;
        ie_d  = ie_q;
        cmp_d = cmp_q;
        set_v = '0;
        clr_v = '0;
        tin_d = {tin_q[1], tin_q[0], tmr_in};
        cin_d = {cin_q[1], cin_q[0], cap_in};

        if (cr_q[2]) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = (pre_q == psc_q) ? '0 : pre_q + 1'b1;
        end

        if (tick_eff) begin
            for (int i = 0; i < ch_n; i++) begin
                set_v[i] = (cnt_q == cmp_q[i]);
            end
            if (cnt_q == re_q) begin
                cnt_d        = '0;
                set_v[ovf_b] = 1'b1;
                if (cr_q[1]) begin
                    cr_d[0] = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (c_edge) begin
            cap_d         = cnt_q;
            set_v[cap_b]  = 1'b1;
            set_v[covr_b] = is_q[cap_b];
        end

        if (wr_cr) begin
            cr_d = wd[4:0];
            if (!en && wd[0]) begin
                pre_d = '0;
            end
        end
        if (wr_psc) psc_d = wd[psc_w-1:0];
        if (wr_re)  re_d  = wd[tmr_w-1:0];
        if (wr_cnt) begin
            cnt_d = wd[tmr_w-1:0];
            pre_d = '0;
        end
        if (wr_ie) ie_d  = wd[is_w-1:0];
        if (wr_is) clr_v = wd[is_w-1:0];
        for (int i = 0; i < ch_n; i++) begin
            if (we && (widx == 6'(8 + i))) begin
                cmp_d[i] = wd[tmr_w-1:0];
            end
        end

        // hardware set beats a same-cycle clear
        is_d = (is_q & ~clr_v) | set_v;

        for (int i = 0; i < ch_n; i++) begin
            out_d[i] = en && (cnt_q < cmp_q[i]);
        end
        irq_d = |(is_q & ie_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cr_q  <= '0;
            psc_q <= '0;
            pre_q <= '0;
            re_q  <= '1;
            cnt_q <= '0;
            cap_q <= '0;
            ie_q  <= '0;
            is_q  <= '0;
            tin_q <= '0;
            cin_q <= '0;
            out_q <= '0;
            irq_q <= 1'b0;
            for (int i = 0; i < ch_n; i++) begin
                cmp_q[i] <= '0;
            end
        end else begin
            cr_q  <= cr_d;
            psc_q <= psc_d;
            pre_q <= pre_d;
            re_q  <= re_d;
            cnt_q <= cnt_d;
            cap_q <= cap_d;
            ie_q  <= ie_d;
            is_q  <= is_d;
            tin_q <= tin_d;
            cin_q <= cin_d;
            out_q <= out_d;
            irq_q <= irq_d;
            for (int i = 0; i < ch_n; i++) begin
                cmp_q[i] <= cmp_d[i];
            end
        end
    end

    always_comb begin
        rd = '0;
        unique case (widx)
            6'd0: rd[4:0]       = cr_q;
            6'd1: rd[psc_w-1:0] = psc_q;
            6'd2: rd[tmr_w-1:0] = re_q;
            6'd3: rd[tmr_w-1:0] = cnt_q;
            6'd4: rd[is_w-1:0]  = ie_q;
            6'd5: rd[is_w-1:0]  = is_q;
            6'd6: rd[tmr_w-1:0] = cap_q;
            default: begin
                for (int i = 0; i < ch_n; i++) begin
                    if (widx == 6'(8 + i)) begin
                        rd[tmr_w-1:0] = cmp_q[i];
                    end
                end
            end
        endcase
    end

    assign tmr_out = out_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_tmr_mc.sv
// Randomised and directed bench for tmr_mc against a register-level
// behavioural model of the timer.
module tb_tmr_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  addr = '0;
    logic        we = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        irq;
    logic        tmr_in = 1'b0;
    logic        cap_in = 1'b0;
    logic [3:0]  tmr_out;

    tmr_mc #(.tmr_w(16), .psc_w(8), .ch_n(4)) dut (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .wd(wd), .rd(rd),
        .irq(irq), .tmr_in(tmr_in), .cap_in(cap_in), .tmr_out(tmr_out)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model: architectural register values
    bit [31:0] m_cr, m_psc, m_re, m_cnt, m_ie, m_is, m_cap, m_pre;
    bit [31:0] m_cmp [4];
    bit        ts [3];
    bit        cs [3];
    bit [3:0]  m_out;
    bit        m_irq;
    logic [31:0] rd_s;
    logic [3:0]  out_s;

    function automatic void m_reset();
        m_cr = 0; m_psc = 0; m_re = 32'hFFFF; m_cnt = 0; m_ie = 0;
        m_is = 0; m_cap = 0; m_pre = 0; m_out = 0; m_irq = 0;
        for (int i = 0; i < 4; i++) m_cmp[i] = 0;
        for (int i = 0; i < 3; i++) begin ts[i] = 0; cs[i] = 0; end
    endfunction

    function automatic bit [31:0] m_rd(input bit [7:0] a);
        int k = int'(a >> 2);
        if (k == 0) return m_cr;
        if (k == 1) return m_psc;
        if (k == 2) return m_re;
        if (k == 3) return m_cnt;
        if (k == 4) return m_ie;
        if (k == 5) return m_is;
        if (k == 6) return m_cap;
        if (k >= 8 && k < 12) return m_cmp[k-8];
        return 0;
    endfunction

    function automatic void m_step();
        int  k = int'(addr >> 2);
        bit  en = m_cr[0], os = m_cr[1], ext = m_cr[2];
        bit  t_e, c_e, tick;
        bit [31:0] n_cr = m_cr, n_pre = m_pre, n_cnt = m_cnt, n_cap = m_cap;
        bit [31:0] set = 0, clr = 0;
        // edges seen in this cycle come from pin samples two and three edges old
        t_e = m_cr[3] ? (ts[2] && !ts[1]) : (ts[1] && !ts[2]);
        c_e = m_cr[4] ? (cs[2] && !cs[1]) : (cs[1] && !cs[2]);
        tick = en && (ext ? t_e : (m_pre == m_psc));
        if (we && k == 3) tick = 0;
        for (int i = 0; i < 4; i++) m_out[i] = en && (m_cnt < m_cmp[i]);
        m_irq = (m_is & m_ie) != 0;
        if (ext) n_pre = 0;
        else if (en) n_pre = (m_pre == m_psc) ? 0 : m_pre + 1;
        if (tick) begin
            for (int i = 0; i < 4; i++) if (m_cnt == m_cmp[i]) set |= (1 << i);
            if (m_cnt == m_re) begin
                n_cnt = 0;
                set |= 32'h10;
                if (os) n_cr &= ~32'h1;
            end else begin
                n_cnt = (m_cnt + 1) % 65536;
            end
        end
        if (c_e) begin
            n_cap = m_cnt;
            set |= 32'h20;
            if (m_is[5]) set |= 32'h40;
        end
        if (we) begin
            if (k == 0) begin
                n_cr = wd % 32;
                if (!en && wd[0]) n_pre = 0;
            end
            if (k == 1) m_psc = wd % 256;
            if (k == 2) m_re = wd % 65536;
            if (k == 3) begin n_cnt = wd % 65536; n_pre = 0; end
            if (k == 4) m_ie = wd % 128;
            if (k == 5) clr = wd % 128;
            if (k >= 8 && k < 12) m_cmp[k-8] = wd % 65536;
        end
        m_is = (m_is & ~clr) | set;
        m_cr = n_cr; m_pre = n_pre; m_cnt = n_cnt; m_cap = n_cap;
        ts[2] = ts[1]; ts[1] = ts[0]; ts[0] = tmr_in;
        cs[2] = cs[1]; cs[1] = cs[0]; cs[0] = cap_in;
    endfunction

    task automatic cyc();
        @(negedge clk);
        rd_s  = rd;
        out_s = tmr_out;
        chk("rd", rd, m_rd(addr));
        chk("irq", {31'b0, irq}, {31'b0, m_irq});
        chk("tmr_out", {28'b0, tmr_out}, {28'b0, m_out});
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic wr(input bit [7:0] a, input bit [31:0] d);
        addr = a; we = 1'b1; wd = d;
        cyc();
        we = 1'b0; wd = '0;
    endtask

    task automatic peek(input string tag, input bit [7:0] a,
                        input bit [31:0] exp);
        addr = a;
        cyc();
        chk(tag, rd_s, exp);
    endtask

    int s0, s1, s2, guard;

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        peek("rst_re", 8'h08, 32'hFFFF);
        peek("rst_cr", 8'h00, 32'h0);
        peek("rst_cnt", 8'h0C, 32'h0);

        // prescaled counting, OVF and irq
        wr(8'h04, 3); wr(8'h08, 9); wr(8'h10, 32'h10); wr(8'h00, 1);
        addr = 8'h0C;
        repeat (45) cyc();
        peek("ovf_is", 8'h14, 32'h1F);
        chk("ovf_irq", {31'b0, irq}, 32'h1);

        // PWM channels
        wr(8'h00, 0); wr(8'h0C, 0); wr(8'h04, 0);
        wr(8'h20, 4); wr(8'h24, 0); wr(8'h28, 12);
        wr(8'h00, 1);
        repeat (5) cyc();
        s0 = 0; s1 = 0; s2 = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            s0 += out_s[0]; s1 += out_s[1]; s2 += out_s[2];
        end
        chk("pwm0", s0, 8);
        chk("pwm1", s1, 0);
        chk("pwm2", s2, 20);

        // one-shot
        wr(8'h00, 0); wr(8'h0C, 0); wr(8'h08, 5); wr(8'h14, 32'h7F);
        wr(8'h00, 3);
        repeat (20) cyc();
        peek("os_cr", 8'h00, 32'h2);
        peek("os_cnt", 8'h0C, 32'h0);
        peek("os_is", 8'h14, 32'h1B);
        wr(8'h14, 32'h7F);
        repeat (10) cyc();
        peek("os_single", 8'h14, 32'h0);

        // external falling-edge counting
        wr(8'h00, 0); wr(8'h0C, 0); wr(8'h08, 32'hFFFF); wr(8'h00, 13);
        addr = 8'h0C;
        for (int i = 0; i < 7; i++) begin
            tmr_in = 1'b1; repeat (3) cyc();
            tmr_in = 1'b0; repeat (3) cyc();
        end
        repeat (5) cyc();
        peek("ext_cnt", 8'h0C, 32'h7);

        // capture with overrun, then W1C racing a third edge
        wr(8'h00, 0); wr(8'h14, 32'h7F); wr(8'h0C, 3);
        cap_in = 1'b1; repeat (4) cyc();
        cap_in = 1'b0; repeat (4) cyc();
        wr(8'h0C, 8);
        cap_in = 1'b1; repeat (4) cyc();
        cap_in = 1'b0; repeat (4) cyc();
        peek("cap_val", 8'h18, 32'h8);
        peek("cap_is", 8'h14, 32'h60);
        cap_in = 1'b1; cyc(); cyc();
        wr(8'h14, 32'h20);
        peek("cap_w1c", 8'h14, 32'h60);
        cap_in = 1'b0; repeat (4) cyc();

        // asynchronous reset mid-count
        wr(8'h10, 32'h7F); wr(8'h0C, 0); wr(8'h08, 9); wr(8'h04, 0);
        wr(8'h20, 9); wr(8'h00, 1);
        addr = 8'h0C;
        guard = 0;
        while (m_cnt != 6 && guard < 50) begin
            cyc();
            guard++;
        end
        chk("rst_reach6", m_cnt, 6);
        rst = 1'b1;
        #1;
        chk("arst_out", {28'b0, tmr_out}, 32'h0);
        chk("arst_irq", {31'b0, irq}, 32'h0);
        addr = 8'h0C; #1;
        chk("arst_cnt", rd, 32'h0);
        addr = 8'h08; #1;
        chk("arst_re", rd, 32'hFFFF);
        m_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        peek("post_rst_is", 8'h14, 32'h0);

        // randomised register traffic and pin activity
        for (int n = 0; n < 3000; n++) begin
            int k;
            k = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63)
                                            : $urandom_range(0, 11);
            addr = 8'((k << 2) | $urandom_range(0, 3));
            we = ($urandom_range(0, 9) < 3);
            case (k)
                0: wd = $urandom;
                1: wd = {$urandom_range(0, 255) << 8, 8'($urandom_range(0, 3))};
                2: wd = ($urandom_range(0, 7) == 0) ? $urandom
                                                    : $urandom_range(0, 20);
                3: wd = ($urandom_range(0, 3) == 0) ? 32'hFFF0 + $urandom_range(0, 15)
                                                    : $urandom_range(0, 25);
                8, 9, 10, 11: wd = $urandom_range(0, 24);
                default: wd = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) tmr_in = ~tmr_in;
            if ($urandom_range(0, 19) == 0) cap_in = ~cap_in;
            cyc();
        end
        we = 1'b0;

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
